// File: rtl/fetch_prefetch.sv
// Prefetching fetch unit: keeps up to FIFO_DEPTH PC-tagged words queued for decode and handles ALU redirects.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module fetch_prefetch #(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] START_ADDR = '0,
  parameter int                  FIFO_DEPTH = 4,
  parameter int                  ADDR_STEP  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  inst_req,
  output logic [ADDR_WIDTH-1:0] inst_addr,
  input  logic                  inst_valid,
  input  logic [DATA_WIDTH-1:0] inst_data,
  output logic                  dec_valid,
  output logic [DATA_WIDTH-1:0] dec_inst,
  output logic [ADDR_WIDTH-1:0] dec_pc,
  input  logic                  dec_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_flush_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_WIDTH-1:0] drop_addr_q, drop_addr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] inst_mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem_q   [FIFO_DEPTH];
  logic                  push;
  logic                  pop;

  // A response arriving together with a redirect belongs to the old path and is dropped.
  assign push      = (state_q == REQ) && inst_valid && !redirect_valid;
  assign dec_valid = (count_q != '0);
  assign pop       = dec_valid && dec_ready;
  assign dec_inst  = dec_valid ? inst_mem_q[rd_ptr_q] : '0;
  assign dec_pc    = dec_valid ? pc_mem_q[rd_ptr_q]   : '0;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    wr_ptr_d    = wr_ptr_q + PW'(push);
    rd_ptr_d    = rd_ptr_q + PW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    inst_req    = 1'b0;
    inst_addr   = fetch_pc_q;

    case (state_q)
      IDLE: begin
        if (count_q < DEPTH_C) state_d = REQ;
      end
      REQ: begin
        inst_req = 1'b1;
        if (inst_valid) begin
          fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(ADDR_STEP);
          state_d    = (count_d < DEPTH_C) ? REQ : IDLE;
        end
      end
      DROP: begin
        inst_req  = 1'b1;
        inst_addr = drop_addr_q;
        if (inst_valid) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    if (redirect_valid) begin
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      fetch_pc_d = redirect_pc;
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (inst_valid) begin
            state_d = REQ;
          end else begin
            // Request still open at the cache: remember its address until it completes.
            state_d     = DROP;
            drop_addr_d = fetch_pc_q;
          end
        end
        DROP:    state_d = inst_valid ? REQ : DROP;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      fetch_pc_q  <= START_ADDR;
      drop_addr_q <= START_ADDR;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem_q[wr_ptr_q] <= inst_data;
      pc_mem_q[wr_ptr_q]   <= fetch_pc_q;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_flush_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (push)                    perf_fetch_q <= perf_fetch_q + 32'd1;
      if (redirect_valid)          perf_flush_q <= perf_flush_q + 32'd1;
      if (dec_ready && !dec_valid) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt = perf_fetch_q;
  assign perf_flush_cnt = perf_flush_q;
  assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Directed bench for fetch_prefetch: streaming, back-pressure, redirects and async reset.
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic [31:0] inst_data;
  logic        dec_valid;
  logic [31:0] dec_inst;
  logic [31:0] dec_pc;
  logic        dec_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        auto_en;
  logic        man_valid;
  logic [31:0] man_data;

  int n_checks = 0;
  int n_fail   = 0;

  // Auto mode: zero-wait cache that returns data equal to the address.
  assign inst_valid = auto_en ? inst_req  : man_valid;
  assign inst_data  = auto_en ? inst_addr : man_data;

  fetch_prefetch dut (
    .clk            (clk),
    .rst            (rst),
    .inst_req       (inst_req),
    .inst_addr      (inst_addr),
    .inst_valid     (inst_valid),
    .inst_data      (inst_data),
    .dec_valid      (dec_valid),
    .dec_inst       (dec_inst),
    .dec_pc         (dec_pc),
    .dec_ready      (dec_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b0;
    auto_en        = 1'b0;
    man_valid      = 1'b0;
    man_data       = '0;
    dec_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    tick();
    tick();
    chk("rst_inst_req",  64'(inst_req),  64'd0);
    chk("rst_inst_addr", 64'(inst_addr), 64'd0);
    chk("rst_dec_valid", 64'(dec_valid), 64'd0);
    chk("rst_dec_inst",  64'(dec_inst),  64'd0);
    chk("rst_dec_pc",    64'(dec_pc),    64'd0);

    rst = 1'b1;
    #1;
    chk("release_no_req", 64'(inst_req), 64'd0);
    tick();
    chk("first_req",      64'(inst_req),  64'd1);
    chk("first_req_addr", 64'(inst_addr), 64'd0);

    // Streaming: one word per cycle, pc sequence 0,1,2,... without gaps.
    auto_en   = 1'b1;
    dec_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("stream_valid", 64'(dec_valid), 64'd1);
      chk("stream_pc",    64'(dec_pc),    64'(i));
      chk("stream_inst",  64'(dec_inst),  64'(i));
    end

    // Back-pressure: queue holds pc 7, three more responses fill it, then requests stop.
    dec_ready = 1'b0;
    tick();
    chk("bp_req_1", 64'(inst_req), 64'd1);
    tick();
    chk("bp_req_2", 64'(inst_req), 64'd1);
    tick();
    chk("bp_full_noreq", 64'(inst_req), 64'd0);
    chk("bp_hold_pc",    64'(dec_pc),   64'd7);
    tick();
    chk("bp_still_noreq", 64'(inst_req),  64'd0);
    chk("bp_hold_valid",  64'(dec_valid), 64'd1);
    chk("bp_hold_pc2",    64'(dec_pc),    64'd7);
    chk("bp_hold_inst",   64'(dec_inst),  64'd7);

    dec_ready = 1'b1;
    tick();
    chk("resume_pc8",   64'(dec_pc),   64'd8);
    chk("resume_idle",  64'(inst_req), 64'd0);
    tick();
    chk("resume_pc9",   64'(dec_pc),    64'd9);
    chk("resume_req",   64'(inst_req),  64'd1);
    chk("resume_addr",  64'(inst_addr), 64'd11);
    for (int k = 10; k <= 12; k++) begin
      tick();
      chk("resume_order", 64'(dec_pc),   64'(k));
      chk("resume_inst",  64'(dec_inst), 64'(k));
    end

    // Drain with the cache silent.
    auto_en = 1'b0;
    tick();
    chk("drain_pc13", 64'(dec_pc), 64'd13);
    tick();
    chk("drain_empty",   64'(dec_valid), 64'd0);
    chk("drain_addr",    64'(inst_addr), 64'd14);
    chk("drain_req",     64'(inst_req),  64'd1);

    // Redirect while a request is pending: stale response must be discarded.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();
    redirect_valid = 1'b0;
    chk("drop_req",       64'(inst_req),  64'd1);
    chk("drop_old_addr",  64'(inst_addr), 64'd14);
    chk("drop_empty",     64'(dec_valid), 64'd0);
    tick();
    tick();
    chk("drop_hold_addr", 64'(inst_addr), 64'd14);
    man_valid = 1'b1;
    man_data  = 32'hDEAD;
    tick();
    man_valid = 1'b0;
    chk("post_drop_addr",  64'(inst_addr), 64'h100);
    chk("post_drop_req",   64'(inst_req),  64'd1);
    chk("post_drop_empty", 64'(dec_valid), 64'd0);
    tick();
    chk("no_dead", 64'(dec_valid), 64'd0);
    man_valid = 1'b1;
    man_data  = 32'hCAFE;
    tick();
    man_valid = 1'b0;
    chk("new_path_valid", 64'(dec_valid), 64'd1);
    chk("new_path_inst",  64'(dec_inst),  64'hCAFE);
    chk("new_path_pc",    64'(dec_pc),    64'h100);
    chk("new_path_next",  64'(inst_addr), 64'h101);
    tick();
    chk("new_path_popped", 64'(dec_valid), 64'd0);

    // Redirect in the same cycle as the response.
    man_valid      = 1'b1;
    man_data       = 32'hBEEF;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    tick();
    man_valid      = 1'b0;
    redirect_valid = 1'b0;
    chk("same_cyc_addr",  64'(inst_addr), 64'h200);
    chk("same_cyc_req",   64'(inst_req),  64'd1);
    chk("same_cyc_empty", 64'(dec_valid), 64'd0);
    tick();
    chk("same_cyc_empty2", 64'(dec_valid), 64'd0);

    // Two redirects while dropping: the last one wins.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    chk("dbl_drop_addr1", 64'(inst_addr), 64'h200);
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    chk("dbl_drop_addr2", 64'(inst_addr), 64'h200);
    man_valid = 1'b1;
    man_data  = 32'h1111;
    tick();
    man_valid = 1'b0;
    chk("dbl_last_wins", 64'(inst_addr), 64'h80);
    chk("dbl_empty",     64'(dec_valid), 64'd0);

    // Async reset mid-REQ with two entries queued.
    dec_ready = 1'b0;
    man_valid = 1'b1;
    man_data  = 32'hA0;
    tick();
    man_data = 32'hA1;
    tick();
    man_valid = 1'b0;
    chk("q2_valid", 64'(dec_valid), 64'd1);
    chk("q2_pc",    64'(dec_pc),    64'h80);
    chk("q2_inst",  64'(dec_inst),  64'hA0);
    chk("q2_addr",  64'(inst_addr), 64'h82);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_req",   64'(inst_req),  64'd0);
    chk("async_rst_valid", 64'(dec_valid), 64'd0);
    chk("async_rst_addr",  64'(inst_addr), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    chk("restart_req",  64'(inst_req),  64'd1);
    chk("restart_addr", 64'(inst_addr), 64'd0);
    chk("restart_empty", 64'(dec_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
